// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcode constants, bypass encodings and hazard FSM state
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_MA = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } state_e;

    function automatic logic uses_rs1(input logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        case (op)
            OP_R, OP_STORE, OP_BRANCH: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - EX operand bypass select; the younger MA result wins over WB
module fwd_sel
    import rv32i_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] ma_rd_i,
    input  logic       ma_werf_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_werf_i,
    output logic [1:0] sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (ma_werf_i && (ma_rd_i != 5'd0) && (ma_rd_i == rs_i)) begin
            sel_o = FWD_MA;
        end else if (wb_werf_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use bubble, bypass selects, data-memory wait FSM
// with timeout, and branch-flush ordering for the 5-stage RV32I pipeline
module hazard_stall_ctrl
    import rv32i_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [6:0]        id_opcode,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              ex_is_load,
    input  logic [4:0]        ex_rd,
    input  logic [4:0]        ex_rs1,
    input  logic [4:0]        ex_rs2,
    input  logic              ex_branch_taken,
    input  logic              ma_mem_op,
    input  logic [4:0]        ma_rd,
    input  logic              ma_werf,
    input  logic [4:0]        wb_rd,
    input  logic              wb_werf,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              stall_pipe,
    output logic              flush_id,
    output logic              flush_ex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_err,
    output logic [PERF_W-1:0] stall_cnt
);

    localparam logic [TO_W:0] TIMEOUT_V = (TO_W + 1)'(MEM_TIMEOUT);

    state_e            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [TO_W:0]     to_cnt_inc;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [1:0] sel_a, sel_b;
    logic       mem_stall, flush, hazard, load_use;

    fwd_sel u_fwd_a (
        .rs_i      (ex_rs1),
        .ma_rd_i   (ma_rd),
        .ma_werf_i (ma_werf),
        .wb_rd_i   (wb_rd),
        .wb_werf_i (wb_werf),
        .sel_o     (sel_a)
    );

    fwd_sel u_fwd_b (
        .rs_i      (ex_rs2),
        .ma_rd_i   (ma_rd),
        .ma_werf_i (ma_werf),
        .wb_rd_i   (wb_rd),
        .wb_werf_i (wb_werf),
        .sel_o     (sel_b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            to_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign to_cnt_inc = {1'b0, to_cnt_q} + 1'b1;

    // The RUN miss cycle is the first wait cycle, hence the counter enters MEM_WAIT at 1.
    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        case (state_q)
            RUN: begin
                if (ma_mem_op && !mem_ack) begin
                    state_d  = MEM_WAIT;
                    to_cnt_d = TO_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_d  = RUN;
                    to_cnt_d = '0;
                end else if (to_cnt_inc >= TIMEOUT_V) begin
                    state_d  = MEM_ERR;
                end else begin
                    to_cnt_d = to_cnt_inc[TO_W-1:0];
                end
            end
            MEM_ERR: state_d = MEM_ERR;
            default: state_d = RUN;
        endcase
    end

    // Priority: memory stall, then branch flush, then load-use bubble.
    always_comb begin
        mem_stall = ((state_q == RUN) && ma_mem_op && !mem_ack)
                  || ((state_q == MEM_WAIT) && !mem_ack)
                  || (state_q == MEM_ERR);
        flush     = ex_branch_taken && !mem_stall;
        hazard    = id_valid && ex_is_load && (ex_rd != 5'd0)
                  && ((uses_rs1(id_opcode) && (id_rs1 == ex_rd))
                   || (uses_rs2(id_opcode) && (id_rs2 == ex_rd)));
        load_use  = (state_q == RUN) && !mem_stall && !flush && hazard;
    end

    always_comb begin
        mem_req    = 1'b0;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        bubble_ex  = 1'b0;
        stall_pipe = 1'b0;
        flush_id   = 1'b0;
        flush_ex   = 1'b0;
        fwd_a      = FWD_RF;
        fwd_b      = FWD_RF;
        mem_err    = 1'b0;
        if (reset) begin
            mem_req    = ((state_q == RUN) && ma_mem_op) || (state_q == MEM_WAIT);
            stall_pipe = mem_stall;
            stall_if   = mem_stall || load_use;
            stall_id   = mem_stall || load_use;
            bubble_ex  = load_use;
            flush_id   = flush;
            flush_ex   = flush;
            fwd_a      = sel_a;
            fwd_b      = sel_b;
            mem_err    = (state_q == MEM_ERR);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_if && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
